// File: rtl/rv32i_types.sv
// Shared pipeline types: arbiter state encoding, owner tags and the streak limit default.
package rv32i_types;

   localparam int ARB_MAX_D_STREAK_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_I    = 2'd1,
      OWNER_D    = 2'd2
   } arb_owner_t;

   function automatic arb_owner_t arb_owner_of(arb_state_t s);
      arb_owner_t o;
      o = OWNER_NONE;
      if (s == I_BUSY) o = OWNER_I;
      if (s == D_BUSY) o = OWNER_D;
      return o;
   endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Holds the granted request on the shared port until its response, so requester
// inputs are free to change while the transaction is in flight.
module arb_req_latch #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_i,
   input  logic                clear_i,
   input  logic                read_i,
   input  logic                write_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wmask_i,
   output logic                read_o,
   output logic                write_o,
   output logic [ADDR_W-1:0]   addr_o,
   output logic [DATA_W-1:0]   wdata_o,
   output logic [DATA_W/8-1:0] wmask_o
);

   logic                read_q,  read_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wmask_q, wmask_d;

   // Load wins over clear; the two never coincide since load only happens in IDLE.
   always_comb begin
      read_d  = read_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      if (load_i) begin
         read_d  = read_i;
         write_d = write_i;
         addr_d  = addr_i;
         wdata_d = wdata_i;
         wmask_d = wmask_i;
      end else if (clear_i) begin
         read_d  = 1'b0;
         write_d = 1'b0;
         addr_d  = '0;
         wdata_d = '0;
         wmask_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_q  <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else begin
         read_q  <= read_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
      end
   end

   assign read_o  = read_q;
   assign write_o = write_q;
   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;
   assign wmask_o = wmask_q;

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one memory port between fetch and MEM; data wins ties, a streak limit
// hands the port to a waiting fetch after MAX_D_STREAK back-to-back data grants.
module cache_port_arbiter
   import rv32i_types::*;
#(
   parameter int MAX_D_STREAK = ARB_MAX_D_STREAK_DEFAULT,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_read,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_resp,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wmask,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_resp,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_resp
);

   localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

   arb_state_t          state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   arb_owner_t          owner;

   logic                d_req;
   logic                grant_d;
   logic                grant_i;
   logic                done;
   logic                ld_read;
   logic                ld_write;
   logic [ADDR_W-1:0]   ld_addr;
   logic [DATA_W-1:0]   ld_wdata;
   logic [DATA_W/8-1:0] ld_wmask;

   assign d_req   = d_read | d_write;
   assign grant_d = (state_q == IDLE) && d_req && !(i_read && (streak_q == STREAK_MAX));
   assign grant_i = (state_q == IDLE) && !grant_d && i_read;
   assign owner   = arb_owner_of(state_q);
   assign done    = (owner != OWNER_NONE) && mem_resp;

   // A simultaneous read+write is illegal; the write is the one launched.
   always_comb begin
      ld_read  = 1'b1;
      ld_write = 1'b0;
      ld_addr  = i_addr;
      ld_wdata = '0;
      ld_wmask = '0;
      if (grant_d) begin
         ld_read  = d_read & ~d_write;
         ld_write = d_write;
         ld_addr  = d_addr;
         ld_wdata = d_wdata;
         ld_wmask = d_wmask;
      end
   end

   arb_req_latch #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_req_latch (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (grant_d | grant_i),
      .clear_i (done),
      .read_i  (ld_read),
      .write_i (ld_write),
      .addr_i  (ld_addr),
      .wdata_i (ld_wdata),
      .wmask_i (ld_wmask),
      .read_o  (mem_read),
      .write_o (mem_write),
      .addr_o  (mem_addr),
      .wdata_o (mem_wdata),
      .wmask_o (mem_wmask)
   );

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      unique case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d  = D_BUSY;
               streak_d = !i_read ? '0 :
                          (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
            end else if (grant_i) begin
               state_d  = I_BUSY;
               streak_d = '0;
            end
         end
         I_BUSY, D_BUSY: begin
            if (mem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
      end
   end

   // Responses go to the owner only; write completions return zero data.
   assign i_resp  = done && (owner == OWNER_I);
   assign d_resp  = done && (owner == OWNER_D);
   assign i_rdata = i_resp ? mem_rdata : '0;
   assign d_rdata = (d_resp && mem_read) ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: requester agents, a fixed-latency memory
// model, and a monitor that pops expected grants as they appear on the shared port.
module tb_cache_port_arbiter;
   import rv32i_types::*;

   localparam int MEM_LAT = 3;
   localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

   logic        clk;
   logic        rst_n;
   logic        i_read;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_resp;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wmask;
   logic [31:0] d_rdata;
   logic        d_resp;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        memRespModel;
   logic        strayResp;
   logic        memBusy;
   int          memCnt;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } reqT;

   typedef struct {
      logic        isD;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] rdata;
   } expT;

   reqT         iReqQ[$];
   reqT         dReqQ[$];
   expT         expQ[$];
   expT         cur;
   logic        active;
   int          checks;
   int          failures;

   cache_port_arbiter #(
      .MAX_D_STREAK (4),
      .ADDR_W       (32),
      .DATA_W       (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_read    (i_read),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_resp    (i_resp),
      .d_read    (d_read),
      .d_write   (d_write),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wmask   (d_wmask),
      .d_rdata   (d_rdata),
      .d_resp    (d_resp),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_rdata (mem_rdata),
      .mem_resp  (mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_resp = memRespModel | strayResp;

   function automatic logic [31:0] memData(logic [31:0] a);
      return (a == 32'h60) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
   endfunction

   task automatic checkOutput(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(logic isD, logic rd, logic wr, logic [31:0] addr,
                                logic [31:0] wdata, logic [3:0] wmask);
      reqT r;
      r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata; r.wmask = wmask;
      if (isD) dReqQ.push_back(r);
      else     iReqQ.push_back(r);
   endtask

   task automatic expectGrant(logic isD, logic rd, logic wr, logic [31:0] addr,
                              logic [31:0] wdata, logic [3:0] wmask);
      expT e;
      e.isD = isD; e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata; e.wmask = wmask;
      e.rdata = rd ? memData(addr) : 32'h0;
      expQ.push_back(e);
   endtask

   task automatic waitIdle(string tag, int maxCycles);
      logic done;
      done = 1'b0;
      for (int n = 0; n < maxCycles && !done; n++) begin
         @(negedge clk);
         done = (expQ.size() == 0) && !active && (iReqQ.size() == 0) && (dReqQ.size() == 0);
      end
      checkOutput({"done_", tag}, 64'(done), 64'd1);
   endtask

   task automatic waitResp(string tag, logic isD, int maxCycles);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < maxCycles && !seen; n++) begin
         @(negedge clk);
         seen = isD ? d_resp : i_resp;
      end
      checkOutput({"resp_seen_", tag}, 64'(seen), 64'd1);
   endtask

   // Fixed-latency memory: responds MEM_LAT cycles after a strobe first appears.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         memBusy      <= 1'b0;
         memCnt       <= 0;
         memRespModel <= 1'b0;
         mem_rdata    <= JUNK;
      end else if (memRespModel) begin
         memRespModel <= 1'b0;
         memBusy      <= 1'b0;
         mem_rdata    <= JUNK;
      end else if (!memBusy) begin
         if (mem_read || mem_write) begin
            memBusy <= 1'b1;
            memCnt  <= MEM_LAT - 1;
         end
      end else if (memCnt == 1) begin
         memRespModel <= 1'b1;
         mem_rdata    <= mem_write ? JUNK : memData(mem_addr);
      end else begin
         memCnt <= memCnt - 1;
      end
   end

   // Requesters hold their request until resp, then move on the following cycle.
   initial begin : iAgent
      logic gotResp;
      i_read = 1'b0;
      i_addr = '0;
      forever begin
         @(negedge clk);
         gotResp = i_resp;
         @(posedge clk);
         #1;
         if (gotResp && iReqQ.size() > 0) void'(iReqQ.pop_front());
         if (iReqQ.size() > 0) begin
            i_read = 1'b1;
            i_addr = iReqQ[0].addr;
         end else begin
            i_read = 1'b0;
         end
      end
   end

   initial begin : dAgent
      logic gotResp;
      d_read  = 1'b0;
      d_write = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      d_wmask = '0;
      forever begin
         @(negedge clk);
         gotResp = d_resp;
         @(posedge clk);
         #1;
         if (gotResp && dReqQ.size() > 0) void'(dReqQ.pop_front());
         if (dReqQ.size() > 0) begin
            d_read  = dReqQ[0].rd;
            d_write = dReqQ[0].wr;
            d_addr  = dReqQ[0].addr;
            d_wdata = dReqQ[0].wdata;
            d_wmask = dReqQ[0].wmask;
         end else begin
            d_read  = 1'b0;
            d_write = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && d_read && d_write)
         $error("[TB] illegal simultaneous d_read and d_write");
   end

   // Monitor: pops the expected grant at launch, then checks hold and steering at resp.
   always @(negedge clk) begin
      if (!rst_n) begin
         active = 1'b0;
      end else begin
         checkOutput("resp_exclusive", 64'(i_resp & d_resp), 64'd0);
         checkOutput("strobe_exclusive", 64'(mem_read & mem_write), 64'd0);
         if ((mem_read || mem_write) && !active) begin
            checkOutput("launch_expected", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
               cur    = expQ.pop_front();
               active = 1'b1;
               checkOutput("launch_read",  64'(mem_read),  64'(cur.rd));
               checkOutput("launch_write", 64'(mem_write), 64'(cur.wr));
               checkOutput("launch_wdata", 64'(mem_wdata), 64'(cur.wdata));
               checkOutput("launch_wmask", 64'(mem_wmask), 64'(cur.wmask));
            end
         end
         if (active)
            checkOutput("addr_hold", 64'(mem_addr), 64'(cur.addr));
         if (!mem_resp) begin
            checkOutput("i_rdata_quiet", 64'(i_rdata), 64'd0);
            checkOutput("d_rdata_quiet", 64'(d_rdata), 64'd0);
         end else if (active) begin
            checkOutput("i_resp_steer", 64'(i_resp), 64'(!cur.isD));
            checkOutput("d_resp_steer", 64'(d_resp), 64'(cur.isD));
            checkOutput(cur.isD ? "d_rdata" : "i_rdata",
                        64'(cur.isD ? d_rdata : i_rdata), 64'(cur.rdata));
            active = 1'b0;
         end else begin
            checkOutput("stray_i_resp", 64'(i_resp), 64'd0);
            checkOutput("stray_d_resp", 64'(d_resp), 64'd0);
            checkOutput("stray_i_rdata", 64'(i_rdata), 64'd0);
         end
      end
   end

   initial begin : mainSeq
      checks    = 0;
      failures  = 0;
      active    = 1'b0;
      strayResp = 1'b0;
      rst_n     = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("rst_mem_read",  64'(mem_read),  64'd0);
      checkOutput("rst_mem_write", 64'(mem_write), 64'd0);
      checkOutput("rst_mem_addr",  64'(mem_addr),  64'd0);
      checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      checkOutput("rst_mem_wmask", 64'(mem_wmask), 64'd0);
      checkOutput("rst_resps",     64'({i_resp, d_resp}), 64'd0);
      checkOutput("rst_rdata",     64'({i_rdata, d_rdata}), 64'd0);
      checkOutput("rst_state",     64'(dut.state_q), 64'(IDLE));
      checkOutput("rst_streak",    64'(dut.streak_q), 64'd0);
      rst_n = 1'b1;

      // Stray response while idle must not produce a completion.
      @(posedge clk); #2 strayResp = 1'b1;
      @(posedge clk); #2 strayResp = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("stray_state", 64'(dut.state_q), 64'(IDLE));

      // Single fetch: launch exactly one cycle after the request is sampled.
      @(posedge clk); #2;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 4'h0);
      expectGrant(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 4'h0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("fetch_not_early", 64'(mem_read), 64'd0);
      @(negedge clk);
      checkOutput("fetch_launch", 64'(mem_read), 64'd1);
      checkOutput("fetch_addr", 64'(mem_addr), 64'h60);
      waitIdle("fetch", 40);

      // Simultaneous requests: data first, fetch in the idle cycle after d_resp.
      @(posedge clk); #2;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h64, 32'h0, 4'h0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
      expectGrant(1'b1, 1'b0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
      expectGrant(1'b0, 1'b1, 1'b0, 32'h64, 32'h0, 4'h0);
      waitResp("simul_d", 1'b1, 40);
      @(negedge clk);
      checkOutput("simul_gap", 64'({mem_read, mem_write}), 64'd0);
      @(negedge clk);
      checkOutput("simul_i_launch", 64'({mem_read, mem_addr}), {31'd0, 1'b1, 32'h64});
      waitIdle("simul", 40);

      // Starvation guard: four data grants, then the waiting fetch, then data again.
      @(posedge clk); #2;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
      for (int k = 0; k < 6; k++)
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h2100 + 32'(k * 4), 32'h0, 4'h0);
      for (int k = 0; k < 4; k++)
         expectGrant(1'b1, 1'b1, 1'b0, 32'h2100 + 32'(k * 4), 32'h0, 4'h0);
      expectGrant(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
      for (int k = 4; k < 6; k++)
         expectGrant(1'b1, 1'b1, 1'b0, 32'h2100 + 32'(k * 4), 32'h0, 4'h0);
      waitResp("starve_i", 1'b0, 80);
      checkOutput("starve_streak_cleared", 64'(dut.streak_q), 64'd0);
      waitIdle("starve", 80);

      // Input stability: a changed d_addr must not reach the port mid-transaction.
      @(posedge clk); #2;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
      expectGrant(1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
      for (int n = 0; n < 20 && !mem_read; n++) @(negedge clk);
      checkOutput("stab_launch", 64'(mem_read), 64'd1);
      if (dReqQ.size() > 0) dReqQ[0].addr = 32'h3000;
      repeat (2) @(negedge clk);
      checkOutput("stab_d_addr_changed", 64'(d_addr), 64'h3000);
      checkOutput("stab_mem_addr", 64'(mem_addr), 64'h2000);
      waitIdle("stab", 40);

      // Reset mid-transaction: abandoned without a response, then a clean grant.
      @(posedge clk); #2;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h4000, 32'h0, 4'h0);
      expectGrant(1'b1, 1'b1, 1'b0, 32'h4000, 32'h0, 4'h0);
      for (int n = 0; n < 20 && !mem_read; n++) @(negedge clk);
      checkOutput("mid_launch", 64'(mem_read), 64'd1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      dReqQ.delete();
      #1;
      checkOutput("mid_rst_strobes", 64'({mem_read, mem_write}), 64'd0);
      checkOutput("mid_rst_addr", 64'(mem_addr), 64'd0);
      checkOutput("mid_rst_d_resp", 64'(d_resp), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #2 strayResp = 1'b1;
      @(posedge clk); #2 strayResp = 1'b0;
      @(negedge clk);
      checkOutput("mid_state_idle", 64'(dut.state_q), 64'(IDLE));
      @(posedge clk); #2;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h5000, 32'h0, 4'h0);
      expectGrant(1'b1, 1'b1, 1'b0, 32'h5000, 32'h0, 4'h0);
      waitIdle("post_reset", 40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Sits between the pipeline's fetch stage (instruction port) and memory stage (data port) and the single shared physical memory/cache port.
- Grants the shared port to one requester at a time and registers the granted request onto the memory interface.
- Steers the response back to the owner only.
- Data side wins ties, so the older instruction in MEM makes progress; a streak limiter keeps fetch from starving.

Parameters:
MAX_D_STREAK, 4, consecutive data grants allowed while an instruction request waits; must be >= 1
ADDR_W, 32, address width
DATA_W, 32, data width (mask width = DATA_W/8)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
i_read  in  1  instruction read request, level, held until i_resp
i_addr  in  ADDR_W  instruction address
i_rdata  out  DATA_W  instruction read data, valid with i_resp
i_resp  out  1  one-cycle instruction completion pulse
d_read  in  1  data read request, level
d_write  in  1  data write request, level
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wmask  in  DATA_W/8  store byte enables
d_rdata  out  DATA_W  load data, valid with d_resp
d_resp  out  1  one-cycle data completion pulse
mem_read  out  1  shared port read strobe, held until mem_resp
mem_write  out  1  shared port write strobe, held until mem_resp
mem_addr  out  ADDR_W  shared port address
mem_wdata  out  DATA_W  shared port write data
mem_wmask  out  DATA_W/8  shared port byte enables
mem_rdata  in  DATA_W  shared port read data
mem_resp  in  1  shared port completion pulse

Behaviour:
- States: IDLE, I_BUSY, D_BUSY; encoding goes in the package.
- Reset (async assert, sync release): state=IDLE, streak=0.
  - mem_read, mem_write, mem_addr, mem_wdata, mem_wmask all 0.
  - i_resp=d_resp=0; i_rdata=d_rdata=0 while not responding.
- IDLE, in priority order:
  - If d_req=(d_read|d_write) and not (i_read and streak==MAX_D_STREAK): go to D_BUSY.
  - Else if i_read: go to I_BUSY.
  - Else stay in IDLE.
- Registered launch: on entering a BUSY state, the mem_* outputs are loaded from the winner's inputs.
  - Request sampled in IDLE at cycle t gives mem_read/mem_write high from cycle t+1.
  - mem_* outputs are held constant until mem_resp.
- I grant: mem_read=1, mem_write=0, mem_wmask=0, mem_wdata=0.
- D grant: mem_write=d_write; mem_read=d_read & ~d_write.
  - d_read&d_write together is illegal; write wins, and a bench assertion flags it.
- BUSY with mem_resp=1 in cycle k:
  - Owner's resp is driven high combinationally in cycle k; owner's rdata=mem_rdata in cycle k (0 for writes).
  - Non-owner resp stays 0.
  - mem_read/mem_write go to 0 at k+1; state returns to IDLE at k+1.
  - Minimum transaction spacing is mem latency + 1 idle/arbitration cycle.
- Requesters deassert (or present a new request) in the cycle after their resp. The arbiter re-samples in IDLE at k+1.
- Streak counter (width clog2(MAX_D_STREAK+1)):
  - On a D grant with i_read=1: increment, saturating at MAX_D_STREAK.
  - On a D grant with i_read=0: clear to 0.
  - On an I grant: clear to 0.
- mem_resp in IDLE (including stray responses after a mid-transaction reset): ignored, no resp pulse.
- Reset mid-transaction: mem strobes drop asynchronously, the transaction is abandoned, and there is no resp to either side.
- Request inputs changing while BUSY have no effect on mem_* outputs; the latched copy is used.
- Only one of i_resp/d_resp is ever high in a cycle; mem_read&mem_write is never high.

Decomposition:
- rv32i_types (shared package) gains arb_state_t {IDLE, I_BUSY, D_BUSY} and an arb_owner_t enum for debug/tracing.
- MAX_D_STREAK stays a module parameter, with its default constant in the package.
- One natural sub-module: arb_req_latch, which registers {read, write, addr, wdata, wmask} on load and clears on resp/reset.
- Everything else (FSM, streak counter, response steering) lives in cache_port_arbiter.

Test Plan:
- Reset then idle: rst_n=0 mid-cycle -> all outputs 0 immediately; stray mem_resp in IDLE -> no i_resp/d_resp.
- Single fetch:
  - Stimulus: i_read=1, i_addr=0x60; memory responds 3 cycles after mem_read with 0x00000013.
  - Required: mem_read from t+1, mem_addr=0x60; i_resp one cycle with i_rdata=0x13; d_resp stays 0.
- Simultaneous requests:
  - Stimulus: i_read=1 @0x64 and d_write=1 @0x1000, wdata=0xDEADBEEF, wmask=0xF, in the same cycle.
  - Required: data served first (mem_write, mem_wmask=0xF); fetch is granted in the IDLE cycle after d_resp.
- Starvation guard:
  - Stimulus: i_read held high; d_read re-asserted immediately after every d_resp, MAX_D_STREAK=4.
  - Required: exactly 4 data grants, then 1 instruction grant, then data resumes; streak counter reads 0 after the I grant.
- Input stability: change d_addr 0x2000->0x3000 while D_BUSY -> mem_addr stays 0x2000 until mem_resp.
- Reset mid-transaction: assert rst_n=0 while D_BUSY, release, then pulse mem_resp -> no d_resp; next d_read is granted cleanly from IDLE.
